// File: rtl/post_state_mac.sv
// Posterior state update x_post = x_prior + K*(z_meas - z_hat), one shared serial MAC; done NX*NZ+1 cycles after accept.
// No backpressure: start is taken only in IDLE, and start while busy is dropped without queueing.
module post_state_mac #(
  parameter int N    = 16,
  parameter int FRAC = 8,
  parameter int NX   = 2,
  parameter int NZ   = 2,
  parameter int SAT  = 1,
  parameter int RND  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [NX*N-1:0]    x_prior,
  input  logic [NZ*N-1:0]    z_meas,
  input  logic [NZ*N-1:0]    z_hat,
  input  logic [NX*NZ*N-1:0] k_gain,
  output logic               busy,
  output logic               done,
  output logic               ovf,
  output logic [NX*N-1:0]    X_post
);

  localparam int AW = 2*N + 2 + $clog2(NZ+1);
  localparam int IW = (NX > 1) ? $clog2(NX) : 1;
  localparam int JW = (NZ > 1) ? $clog2(NZ) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(NX-1);
  localparam logic [JW-1:0] J_LAST = JW'(NZ-1);
  localparam logic [AW-1:0] RND_ADD = (RND != 0) ? (AW'(1) << (FRAC-1)) : '0;
  localparam logic [N-1:0]  MAX_V = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]  MIN_V = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [NX*N-1:0]       xp_r;
  logic [NX*NZ*N-1:0]    k_r;
  logic [NZ*(N+1)-1:0]   e_r;
  logic [NX*N-1:0]       res_buf;
  logic [AW-1:0]         acc;
  logic [IW-1:0]         i_r;
  logic [JW-1:0]         j_r;
  logic                  ovf_acc;

  logic signed [N-1:0]   k_sel;
  logic signed [N:0]     e_sel;
  logic signed [2*N:0]   prod;
  logic [AW-1:0]         acc_nxt;
  logic signed [AW-1:0]  rsum;
  logic signed [AW-1:0]  v;
  logic                  fits;
  logic [N-1:0]          res;
  logic [NX*N-1:0]       fin_vec;
  logic                  row_end;
  logic                  last_row;

  function automatic logic [AW-1:0] ext_x(input logic [N-1:0] x);
    return {{(AW-N){x[N-1]}}, x} << FRAC;
  endfunction

  assign row_end  = (j_r == J_LAST);
  assign last_row = (i_r == I_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_MAC;
      S_MAC:   if (row_end && last_row) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // Product and accumulator are wide enough to be exact; only the final row value can clip.
  always_comb begin
    k_sel   = k_r[(int'(i_r)*NZ + int'(j_r))*N +: N];
    e_sel   = e_r[int'(j_r)*(N+1) +: N+1];
    prod    = (2*N+1)'(k_sel) * (2*N+1)'(e_sel);
    acc_nxt = acc + {{(AW-2*N-1){prod[2*N]}}, prod};
    rsum    = acc_nxt + RND_ADD;
    v       = rsum >>> FRAC;
    fits    = (v[AW-1:N-1] == {(AW-N+1){v[N-1]}});
    if (fits)          res = v[N-1:0];
    else if (SAT != 0) res = v[AW-1] ? MIN_V : MAX_V;
    else               res = v[N-1:0];
    fin_vec = res_buf;
    fin_vec[int'(i_r)*N +: N] = res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xp_r    <= '0;
      k_r     <= '0;
      e_r     <= '0;
      res_buf <= '0;
      acc     <= '0;
      i_r     <= '0;
      j_r     <= '0;
      ovf_acc <= 1'b0;
      ovf     <= 1'b0;
      X_post  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            xp_r <= x_prior;
            k_r  <= k_gain;
            for (int j = 0; j < NZ; j++) begin
              e_r[j*(N+1) +: N+1] <= {z_meas[j*N+N-1], z_meas[j*N +: N]}
                                   - {z_hat[j*N+N-1], z_hat[j*N +: N]};
            end
            acc     <= ext_x(x_prior[N-1:0]);
            i_r     <= '0;
            j_r     <= '0;
            ovf_acc <= 1'b0;
          end
        end
        S_MAC: begin
          if (row_end) begin
            res_buf <= fin_vec;
            ovf_acc <= ovf_acc | ~fits;
            j_r     <= '0;
            if (last_row) begin
              // Publish on the edge into DONE so X_post/ovf are valid alongside done.
              X_post <= fin_vec;
              ovf    <= ovf_acc | ~fits;
              acc    <= acc_nxt;
            end else begin
              i_r <= i_r + IW'(1);
              acc <= ext_x(xp_r[(int'(i_r)+1)*N +: N]);
            end
          end else begin
            j_r <= j_r + JW'(1);
            acc <= acc_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_post_state_mac.sv
// Bench for post_state_mac: hand vectors, handshake/reset sequences, and random runs vs an arithmetic model.
module tb_post_state_mac;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // group 0: 2x2, group 1: 3x1, group 2: 1x4 (two SAT/RND variants each)
  logic        st22 = 0, st31 = 0, st14 = 0;
  logic [31:0] x22 = 0, z22 = 0, h22 = 0;
  logic [63:0] k22 = 0;
  logic [47:0] x31 = 0, k31 = 0;
  logic [15:0] z31 = 0, h31 = 0, x14 = 0;
  logic [63:0] z14 = 0, h14 = 0, k14 = 0;

  logic bA, dA, oA, bB, dB, oB, bC, dC, oC, bD, dD, oD, bE, dE, oE, bF, dF, oF;
  logic [31:0] XA, XB;
  logic [47:0] XC, XD;
  logic [15:0] XE, XF;

  post_state_mac #(.NX(2), .NZ(2), .SAT(1), .RND(0)) u_a (.clk(clk), .rst_n(rst_n), .start(st22),
    .x_prior(x22), .z_meas(z22), .z_hat(h22), .k_gain(k22), .busy(bA), .done(dA), .ovf(oA), .X_post(XA));
  post_state_mac #(.NX(2), .NZ(2), .SAT(0), .RND(1)) u_b (.clk(clk), .rst_n(rst_n), .start(st22),
    .x_prior(x22), .z_meas(z22), .z_hat(h22), .k_gain(k22), .busy(bB), .done(dB), .ovf(oB), .X_post(XB));
  post_state_mac #(.NX(3), .NZ(1), .SAT(0), .RND(0)) u_c (.clk(clk), .rst_n(rst_n), .start(st31),
    .x_prior(x31), .z_meas(z31), .z_hat(h31), .k_gain(k31), .busy(bC), .done(dC), .ovf(oC), .X_post(XC));
  post_state_mac #(.NX(3), .NZ(1), .SAT(1), .RND(1)) u_d (.clk(clk), .rst_n(rst_n), .start(st31),
    .x_prior(x31), .z_meas(z31), .z_hat(h31), .k_gain(k31), .busy(bD), .done(dD), .ovf(oD), .X_post(XD));
  post_state_mac #(.NX(1), .NZ(4), .SAT(1), .RND(0)) u_e (.clk(clk), .rst_n(rst_n), .start(st14),
    .x_prior(x14), .z_meas(z14), .z_hat(h14), .k_gain(k14), .busy(bE), .done(dE), .ovf(oE), .X_post(XE));
  post_state_mac #(.NX(1), .NZ(4), .SAT(0), .RND(1)) u_f (.clk(clk), .rst_n(rst_n), .start(st14),
    .x_prior(x14), .z_meas(z14), .z_hat(h14), .k_gain(k14), .busy(bF), .done(dF), .ovf(oF), .X_post(XF));

  logic [15:0] xv[4], zv[4], hv[4], kv[8];
  logic [15:0] expa[4], expb[4], mx[4];
  logic        ova, ovb, mo;

  typedef struct packed {
    logic [1:0][15:0] x, z, h;
    logic [3:0][15:0] k;
    logic [1:0][15:0] ea;
    logic             oa;
    logic [1:0][15:0] eb;
    logic             ob;
  } vec_t;
  vec_t tbl[8];

  function automatic vec_t mk(logic [31:0] x, logic [31:0] z, logic [31:0] h, logic [63:0] k,
                              logic [31:0] ea, logic oa, logic [31:0] eb, logic ob);
    vec_t r;
    r.x = x; r.z = z; r.h = h; r.k = k; r.ea = ea; r.oa = oa; r.eb = eb; r.ob = ob;
    return r;
  endfunction

  function automatic int nx_of(int g); return (g == 0) ? 2 : ((g == 1) ? 3 : 1); endfunction
  function automatic int nz_of(int g); return (g == 0) ? 2 : ((g == 1) ? 1 : 4); endfunction
  function automatic int sat_of(int g, int n);
    return (g == 0) ? (n == 0 ? 1 : 0) : ((g == 1) ? (n == 0 ? 0 : 1) : (n == 0 ? 1 : 0));
  endfunction
  function automatic int rnd_of(int g, int n);
    return (g == 0) ? (n == 0 ? 0 : 1) : ((g == 1) ? (n == 0 ? 0 : 1) : (n == 0 ? 0 : 1));
  endfunction

  function automatic logic get_done(int g); return (g == 0) ? dA : ((g == 1) ? dC : dE); endfunction
  function automatic logic get_busy(int g); return (g == 0) ? bA : ((g == 1) ? bC : bE); endfunction
  function automatic logic get_ovf(int g, int n);
    if (g == 0) return n == 0 ? oA : oB;
    if (g == 1) return n == 0 ? oC : oD;
    return n == 0 ? oE : oF;
  endfunction
  function automatic logic [63:0] get_x(int g, int n);
    if (g == 0) return n == 0 ? 64'(XA) : 64'(XB);
    if (g == 1) return n == 0 ? 64'(XC) : 64'(XD);
    return n == 0 ? 64'(XE) : 64'(XF);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic longint s16(logic [15:0] a);
    return longint'(signed'(a));
  endfunction

  // x_i*2^8 + sum K(i,j)*e_j, optional +0.5 LSB, floor, then clip or wrap to 16 bits
  task automatic model(input int nx, input int nz, input int sat, input int rnd);
    longint acc, v;
    mo = 0;
    for (int i = 0; i < 4; i++) mx[i] = 0;
    for (int i = 0; i < nx; i++) begin
      acc = s16(xv[i]) * 256;
      for (int j = 0; j < nz; j++) acc += s16(kv[i*nz+j]) * (s16(zv[j]) - s16(hv[j]));
      if (rnd != 0) acc += 128;
      v = acc >>> 8;
      if (v > 32767 || v < -32768) begin
        mo = 1;
        mx[i] = (sat != 0) ? ((v > 0) ? 16'h7FFF : 16'h8000) : v[15:0];
      end else begin
        mx[i] = v[15:0];
      end
    end
  endtask

  task automatic drive(input int g);
    case (g)
      0: begin
        x22 = {xv[1], xv[0]}; z22 = {zv[1], zv[0]}; h22 = {hv[1], hv[0]};
        k22 = {kv[3], kv[2], kv[1], kv[0]};
      end
      1: begin
        x31 = {xv[2], xv[1], xv[0]}; z31 = zv[0]; h31 = hv[0]; k31 = {kv[2], kv[1], kv[0]};
      end
      default: begin
        x14 = xv[0]; z14 = {zv[3], zv[2], zv[1], zv[0]}; h14 = {hv[3], hv[2], hv[1], hv[0]};
        k14 = {kv[3], kv[2], kv[1], kv[0]};
      end
    endcase
  endtask

  task automatic set_start(input int g, input logic b);
    if (g == 0) st22 = b; else if (g == 1) st31 = b; else st14 = b;
  endtask

  task automatic scramble(input int g);
    if (g == 0) begin
      x22 = $urandom(); z22 = $urandom(); h22 = $urandom(); k22 = {$urandom(), $urandom()};
    end else if (g == 1) begin
      x31 = {16'($urandom()), 32'($urandom())}; z31 = 16'($urandom()); h31 = 16'($urandom());
      k31 = {16'($urandom()), 32'($urandom())};
    end else begin
      x14 = 16'($urandom()); z14 = {$urandom(), $urandom()}; h14 = {$urandom(), $urandom()};
      k14 = {$urandom(), $urandom()};
    end
  endtask

  // One run: pulse start, watch busy/X_post until done, compare both variants against expa/expb.
  task automatic run(input int g, input bit scr);
    int nx, cyc;
    bit got, busy_ok, stable;
    logic [63:0] prevx;
    nx = nx_of(g);
    prevx = get_x(g, 0);
    @(negedge clk);
    drive(g);
    set_start(g, 1'b1);
    @(posedge clk);
    #1 set_start(g, 1'b0);
    if (scr) scramble(g);
    cyc = 0; got = 0; busy_ok = 1; stable = 1;
    while (!got && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (get_done(g)) got = 1;
      else begin
        if (!get_busy(g)) busy_ok = 0;
        if (get_x(g, 0) != prevx) stable = 0;
      end
    end
    chk($sformatf("g%0d latency", g), got ? cyc : -1, nx * nz_of(g) + 1);
    chk($sformatf("g%0d busy_during_run", g), busy_ok, 1);
    chk($sformatf("g%0d busy_at_done", g), get_busy(g), 1);
    chk($sformatf("g%0d xpost_stable", g), stable, 1);
    for (int i = 0; i < nx; i++) begin
      chk($sformatf("g%0d v0 X[%0d]", g, i), get_x(g, 0) >> (16*i) & 64'hFFFF, expa[i]);
      chk($sformatf("g%0d v1 X[%0d]", g, i), get_x(g, 1) >> (16*i) & 64'hFFFF, expb[i]);
    end
    chk($sformatf("g%0d v0 ovf", g), get_ovf(g, 0), ova);
    chk($sformatf("g%0d v1 ovf", g), get_ovf(g, 1), ovb);
    @(negedge clk);
    chk($sformatf("g%0d done_pulse", g), {get_done(g), get_busy(g)}, 0);
  endtask

  task automatic load_row(input int r);
    for (int i = 0; i < 4; i++) begin xv[i] = 0; zv[i] = 0; hv[i] = 0; kv[i] = 0; kv[i+4] = 0; end
    for (int i = 0; i < 2; i++) begin
      xv[i] = tbl[r].x[i]; zv[i] = tbl[r].z[i]; hv[i] = tbl[r].h[i];
      expa[i] = tbl[r].ea[i]; expb[i] = tbl[r].eb[i];
    end
    for (int i = 0; i < 4; i++) kv[i] = tbl[r].k[i];
    ova = tbl[r].oa; ovb = tbl[r].ob;
  endtask

  function automatic logic [15:0] rv(int mode);
    if (mode == 0) return 16'($urandom());
    return 16'(int'($urandom_range(0, 1023)) - 512);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int dq[$];
    int busy_low, mode;
    bit seen;

    tbl[0] = mk(32'hFF80_0100, 32'h0100_0200, 32'h0100_0100, 64'h0080_0040_0040_0080,
                32'hFFC0_0180, 0, 32'hFFC0_0180, 0);
    tbl[1] = mk(32'h0000_7F00, 32'h0000_0100, 0, 64'h0100, 32'h0000_7FFF, 1, 32'h0000_8000, 1);
    tbl[2] = mk(32'h0000_8100, 32'h0000_0100, 0, 64'hFF00, 32'h0000_8000, 0, 32'h0000_8000, 0);
    tbl[3] = mk(32'h0000_8000, 32'h0000_0100, 0, 64'hFF00, 32'h0000_8000, 1, 32'h0000_7F00, 1);
    tbl[4] = mk(0, 32'h0000_0080, 0, 64'h1, 32'h0, 0, 32'h0000_0001, 0);
    tbl[5] = mk(0, 0, 32'h0000_0080, 64'h1, 32'h0000_FFFF, 0, 32'h0, 0);
    tbl[6] = mk(0, 32'h0000_7FFF, 32'h0000_8000, 64'h1, 32'h0000_00FF, 0, 32'h0000_0100, 0);
    tbl[7] = mk(0, 32'h0200_0000, 0, 64'h0001_0300_0100_0000, 32'h0002_0200, 0, 32'h0002_0200, 0);

    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("reset g%0d busy/done", g), {get_busy(g), get_done(g)}, 0);
      for (int n = 0; n < 2; n++) begin
        chk($sformatf("reset g%0d v%0d X_post", g, n), get_x(g, n), 0);
        chk($sformatf("reset g%0d v%0d ovf", g, n), get_ovf(g, n), 0);
      end
    end
    rst_n = 1'b1;

    for (int r = 0; r < 8; r++) begin
      load_row(r);
      run(0, 0);
    end

    // inputs scrambled right after acceptance must not leak into the result
    load_row(0);
    run(0, 1);

    // start held high: done every 6 cycles, one IDLE cycle between runs
    @(negedge clk);
    st22 = 1'b1;
    busy_low = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (dA) dq.push_back(c);
      if (!bA && c <= 17) busy_low++;
    end
    st22 = 1'b0;
    chk("held start done count", dq.size(), 3);
    if (dq.size() == 3) begin
      chk("held start done #1", dq[0], 5);
      chk("held start done #2", dq[1], 11);
      chk("held start done #3", dq[2], 17);
    end
    chk("held start idle cycles", busy_low, 2);
    repeat (8) @(negedge clk);

    // reset in cycle 2 of a run aborts it; X_post was non-zero beforehand
    load_row(1);
    drive(0);
    st22 = 1'b1;
    @(posedge clk);
    #1 st22 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun reset X_post", XA, 0);
    chk("midrun reset busy/done", {bA, dA}, 0);
    chk("midrun reset ovf", oA, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (dA || bA) seen = 1;
    end
    chk("no activity after reset", seen, 0);
    load_row(0);
    run(0, 0);

    for (int g = 0; g < 3; g++) begin
      for (int it = 0; it < 30; it++) begin
        mode = it % 3;
        for (int i = 0; i < 4; i++) begin
          xv[i] = (mode == 2) ? rv(1) : rv(0);
          zv[i] = rv(mode == 0 ? 0 : 1);
          hv[i] = rv(mode == 0 ? 0 : 1);
        end
        for (int i = 0; i < 8; i++) kv[i] = rv(mode == 0 ? 0 : 1);
        model(nx_of(g), nz_of(g), sat_of(g, 0), rnd_of(g, 0));
        expa = mx; ova = mo;
        model(nx_of(g), nz_of(g), sat_of(g, 1), rnd_of(g, 1));
        expb = mx; ovb = mo;
        run(g, it % 5 == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
